store_checker: RTL and testbench

- Synthesizable self-check monitor for the single-cycle RISC-V core's data-memory write bus (MemWrite/DataAdr/WriteData).
- Holds a programmable table of expected (address, data) stores, matched in order or in any order, with an address window whose writes are ignored (scratch/stack) and a cycle timeout.
- Reports pass/fail with a fail code and the offending write, so both the top-level bench and the FPGA build can use it without hard-coded addresses.

---
 rtl/store_checker_pkg.sv | 27 ++
 rtl/store_checker_if.sv | 16 +
 rtl/store_checker_table.sv | 85 ++++++++
 rtl/store_checker.sv | 154 +++++++++++++++
 tb/tb_store_checker.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_checker_pkg.sv
// store_checker_pkg
// Shared types for the data-memory store checker.
//   state_t     : checker FSM states (IDLE, RUN, PASS, FAIL)
//   fail_code_t : encoding reported on the fail_code output
//   idx_width() : index width for a table of n entries, never below 1
package store_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE          = 3'd0,
        FC_UNEXP_ADDR    = 3'd1,
        FC_DATA_MISMATCH = 3'd2,
        FC_TIMEOUT       = 3'd3,
        FC_EMPTY_CFG     = 3'd4
    } fail_code_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/store_checker_if.sv
// store_checker_if
// Data-memory write bus of the single-cycle core, as observed by the checker.
//   mem_write  : core MemWrite strobe
//   data_adr   : core DataAdr (byte address)
//   write_data : core WriteData
// Modports: master (core side, drives the bus), slave (checker side, observes).
interface store_checker_if #(
    parameter int XLEN = 32
);
    logic            mem_write;
    logic [XLEN-1:0] data_adr;
    logic [XLEN-1:0] write_data;

    modport master (output mem_write, data_adr, write_data);
    modport slave  (input  mem_write, data_adr, write_data);
endinterface

// File: rtl/store_checker_table.sv
// store_checker_table
// Expected-store table, hit mask and combinational lookup for the checker.
//   clk, reset              : clock, async active-low reset (clears table and mask)
//   cfg_we/idx/addr/data    : entry write port (already gated off during RUN)
//   clear_hits              : clears the hit mask when a run is armed
//   set_hit                 : marks the current candidate entry as hit
//   match_cnt, active_cnt   : progress and number of active entries
//   look_addr, look_data    : write currently on the bus
//   addr_hit                : a candidate entry with matching address exists
//   data_ok                 : the candidate's expected data equals look_data
module store_checker_table
    import store_checker_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int NUM_CHECKS = 4,
    parameter  int ORDERED    = 1,
    localparam int IDX_W      = idx_width(NUM_CHECKS),
    localparam int CNT_W      = $clog2(NUM_CHECKS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [XLEN-1:0]  cfg_addr,
    input  logic [XLEN-1:0]  cfg_data,
    input  logic             clear_hits,
    input  logic             set_hit,
    input  logic [CNT_W-1:0] match_cnt,
    input  logic [CNT_W-1:0] active_cnt,
    input  logic [XLEN-1:0]  look_addr,
    input  logic [XLEN-1:0]  look_data,
    output logic             addr_hit,
    output logic             data_ok
);

    logic [XLEN-1:0]       entry_addr [NUM_CHECKS];
    logic [XLEN-1:0]       entry_data [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] hit_mask;
    logic [IDX_W-1:0]      cand_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                entry_addr[i] <= '0;
                entry_data[i] <= '0;
            end
        end else if (cfg_we && int'(cfg_idx) < NUM_CHECKS) begin
            entry_addr[cfg_idx] <= cfg_addr;
            entry_data[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_mask <= '0;
        end else if (clear_hits) begin
            hit_mask <= '0;
        end else if (set_hit) begin
            hit_mask[cand_idx] <= 1'b1;
        end
    end

    // Ordered mode only ever looks at the next expected entry. Unordered mode
    // scans downward so the lowest-index unhit active match wins.
    always_comb begin
        addr_hit = 1'b0;
        cand_idx = '0;
        if (ORDERED != 0) begin
            cand_idx = match_cnt[IDX_W-1:0];
            if (int'(match_cnt) < int'(active_cnt) && int'(match_cnt) < NUM_CHECKS &&
                entry_addr[cand_idx] == look_addr) begin
                addr_hit = 1'b1;
            end
        end else begin
            for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
                if (i < int'(active_cnt) && !hit_mask[i] && entry_addr[i] == look_addr) begin
                    addr_hit = 1'b1;
                    cand_idx = IDX_W'(i);
                end
            end
        end
        data_ok = addr_hit && (entry_data[cand_idx] == look_data);
    end

endmodule

// File: rtl/store_checker.sv
// store_checker
// Self-check monitor for the core's data-memory write bus. A table of expected
// (address, data) stores is matched in order or any order; writes into an
// ignored window are skipped and a cycle timeout bounds the run.
//   clk, reset        : core clock, async active-low reset
//   start             : arm the checker (pulse, ignored while running)
//   cfg_we/idx/addr/data : expected-store table write port
//   cfg_count         : number of active entries, sampled on start
//   bus               : observed MemWrite/DataAdr/WriteData (slave modport)
//   busy, done, pass  : RUN / PASS-or-FAIL / PASS status
//   fail_code         : 0 none, 1 unexpected addr, 2 data mismatch, 3 timeout, 4 empty
//   match_cnt         : entries hit so far
//   cycle_cnt         : RUN cycles elapsed (saturating)
//   err_addr/err_data : offending write (0 on timeout / empty config)
module store_checker
    import store_checker_pkg::*;
#(
    parameter  int XLEN           = 32,
    parameter  int NUM_CHECKS     = 4,
    parameter  int ORDERED        = 1,
    parameter  int IGNORE_BASE    = 96,
    parameter  int IGNORE_BYTES   = 4,
    parameter  int TIMEOUT_CYCLES = 1000,
    localparam int IDX_W          = idx_width(NUM_CHECKS),
    localparam int CNT_W          = $clog2(NUM_CHECKS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [XLEN-1:0]  cfg_addr,
    input  logic [XLEN-1:0]  cfg_data,
    input  logic [CNT_W-1:0] cfg_count,
    store_checker_if.slave   bus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2:0]       fail_code,
    output logic [CNT_W-1:0] match_cnt,
    output logic [31:0]      cycle_cnt,
    output logic [XLEN-1:0]  err_addr,
    output logic [XLEN-1:0]  err_data
);

    localparam logic [XLEN:0] IGN_LO = (XLEN+1)'(IGNORE_BASE);
    localparam logic [XLEN:0] IGN_HI = (XLEN+1)'(IGNORE_BASE) + (XLEN+1)'(IGNORE_BYTES);

    state_t           state;
    fail_code_t       code_q;
    logic [CNT_W-1:0] active_cnt;
    logic [CNT_W-1:0] next_match;
    logic             addr_hit;
    logic             data_ok;
    logic             in_ignore;
    logic             sample;
    logic             set_hit;
    logic             timeout_hit;

    assign fail_code  = code_q;
    assign next_match = match_cnt + CNT_W'(1);

    // The ignored window is checked first so scratch/stack writes never reach
    // the table, even if a table entry happens to point into the window.
    assign in_ignore   = (IGNORE_BYTES != 0) &&
                         ({1'b0, bus.data_adr} >= IGN_LO) &&
                         ({1'b0, bus.data_adr} <  IGN_HI);
    assign sample      = (state == RUN) && bus.mem_write && !in_ignore;
    assign set_hit     = sample && addr_hit && data_ok;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cycle_cnt == 32'(TIMEOUT_CYCLES - 1));

    store_checker_table #(
        .XLEN       (XLEN),
        .NUM_CHECKS (NUM_CHECKS),
        .ORDERED    (ORDERED)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we && state != RUN),
        .cfg_idx    (cfg_idx),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .clear_hits (start && state != RUN),
        .set_hit    (set_hit),
        .match_cnt  (match_cnt),
        .active_cnt (active_cnt),
        .look_addr  (bus.data_adr),
        .look_data  (bus.write_data),
        .addr_hit   (addr_hit),
        .data_ok    (data_ok)
    );

    // Decision priority inside RUN: completing hit, then failing write, then
    // timeout. cycle_cnt only advances on edges that stay in RUN, so it reads
    // back the index of the deciding cycle once the run has ended.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            code_q     <= FC_NONE;
            match_cnt  <= '0;
            cycle_cnt  <= '0;
            err_addr   <= '0;
            err_data   <= '0;
            active_cnt <= '0;
        end else if (state == RUN) begin
            if (set_hit) begin
                match_cnt <= next_match;
            end
            if (set_hit && next_match == active_cnt) begin
                state <= PASS;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b1;
            end else if (sample && !set_hit) begin
                state    <= FAIL;
                busy     <= 1'b0;
                done     <= 1'b1;
                code_q   <= addr_hit ? FC_DATA_MISMATCH : FC_UNEXP_ADDR;
                err_addr <= bus.data_adr;
                err_data <= bus.write_data;
            end else if (timeout_hit) begin
                state  <= FAIL;
                busy   <= 1'b0;
                done   <= 1'b1;
                code_q <= FC_TIMEOUT;
            end else if (cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end else if (start) begin
            // A count larger than the table could never complete, so clamp it.
            active_cnt <= (int'(cfg_count) > NUM_CHECKS) ? CNT_W'(NUM_CHECKS) : cfg_count;
            match_cnt  <= '0;
            cycle_cnt  <= '0;
            err_addr   <= '0;
            err_data   <= '0;
            pass       <= 1'b0;
            if (cfg_count == '0) begin
                state  <= FAIL;
                busy   <= 1'b0;
                done   <= 1'b1;
                code_q <= FC_EMPTY_CFG;
            end else begin
                state  <= RUN;
                busy   <= 1'b1;
                done   <= 1'b0;
                code_q <= FC_NONE;
            end
        end
    end

endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker
// Two checkers (ordered and unordered, timeout 50) watch the same bus and
// config inputs. Stimulus pushes hand-computed expected results into one queue
// per checker; a monitor pops and compares whenever a checker raises done.
module tb_store_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;
    logic [2:0]  cfg_count;

    store_checker_if #(.XLEN(32)) bus ();

    logic        o_busy, o_done, o_pass;
    logic [2:0]  o_fail_code, o_match_cnt;
    logic [31:0] o_cycle_cnt, o_err_addr, o_err_data;
    logic        u_busy, u_done, u_pass;
    logic [2:0]  u_fail_code, u_match_cnt;
    logic [31:0] u_cycle_cnt, u_err_addr, u_err_data;

    store_checker #(
        .XLEN(32), .NUM_CHECKS(4), .ORDERED(1),
        .IGNORE_BASE(96), .IGNORE_BYTES(4), .TIMEOUT_CYCLES(50)
    ) dut_ord (
        .clk(clk), .reset(reset), .start(start),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_count(cfg_count), .bus(bus),
        .busy(o_busy), .done(o_done), .pass(o_pass), .fail_code(o_fail_code),
        .match_cnt(o_match_cnt), .cycle_cnt(o_cycle_cnt),
        .err_addr(o_err_addr), .err_data(o_err_data)
    );

    store_checker #(
        .XLEN(32), .NUM_CHECKS(4), .ORDERED(0),
        .IGNORE_BASE(96), .IGNORE_BYTES(4), .TIMEOUT_CYCLES(50)
    ) dut_unord (
        .clk(clk), .reset(reset), .start(start),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_count(cfg_count), .bus(bus),
        .busy(u_busy), .done(u_done), .pass(u_pass), .fail_code(u_fail_code),
        .match_cnt(u_match_cnt), .cycle_cnt(u_cycle_cnt),
        .err_addr(u_err_addr), .err_data(u_err_data)
    );

    typedef struct {
        string       name;
        logic        pass;
        logic [2:0]  code;
        logic [2:0]  mcnt;
        logic [31:0] cyc;
        logic [31:0] eaddr;
        logic [31:0] edata;
    } exp_t;

    exp_t q_o[$];
    exp_t q_u[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    logic o_done_q    = 1'b0;
    logic u_done_q    = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic compareResult(input string tag, input exp_t e, input logic p, input logic [2:0] fc,
                                 input logic [2:0] mc, input logic [31:0] cc,
                                 input logic [31:0] ea, input logic [31:0] ed);
        checkOutput({tag, " ", e.name, " pass"},      {31'd0, p}, {31'd0, e.pass});
        checkOutput({tag, " ", e.name, " fail_code"}, {29'd0, fc}, {29'd0, e.code});
        checkOutput({tag, " ", e.name, " match_cnt"}, {29'd0, mc}, {29'd0, e.mcnt});
        checkOutput({tag, " ", e.name, " cycle_cnt"}, cc, e.cyc);
        checkOutput({tag, " ", e.name, " err_addr"},  ea, e.eaddr);
        checkOutput({tag, " ", e.name, " err_data"},  ed, e.edata);
    endtask

    // Monitor: a rising done marks a finished run; its result is compared
    // against the oldest pending expectation for that checker.
    always @(negedge clk) begin
        if (o_done && !o_done_q) begin
            if (q_o.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL ord unexpected done: got done=1, want no result pending");
            end else begin
                mon_e = q_o.pop_front();
                compareResult("ord", mon_e, o_pass, o_fail_code, o_match_cnt, o_cycle_cnt, o_err_addr, o_err_data);
            end
        end
        if (u_done && !u_done_q) begin
            if (q_u.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unord unexpected done: got done=1, want no result pending");
            end else begin
                mon_e = q_u.pop_front();
                compareResult("unord", mon_e, u_pass, u_fail_code, u_match_cnt, u_cycle_cnt, u_err_addr, u_err_data);
            end
        end
        o_done_q = o_done;
        u_done_q = u_done;
    end

    task automatic expectResult(input bit to_ord, input bit to_unord, input string name,
                                input logic p, input logic [2:0] code, input logic [2:0] mcnt,
                                input logic [31:0] cyc, input logic [31:0] eaddr, input logic [31:0] edata);
        exp_t e;
        e.name  = name;
        e.pass  = p;
        e.code  = code;
        e.mcnt  = mcnt;
        e.cyc   = cyc;
        e.eaddr = eaddr;
        e.edata = edata;
        if (to_ord)   q_o.push_back(e);
        if (to_unord) q_u.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfgEntry(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic startRun(input logic [2:0] cnt);
        cfg_count = cnt;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        bus.mem_write  = 1'b1;
        bus.data_adr   = a;
        bus.write_data = d;
        tick();
        bus.mem_write  = 1'b0;
    endtask

    task automatic waitDrained(input int budget, input string name);
        int n = 0;
        while ((q_o.size() != 0 || q_u.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (q_o.size() != 0 || q_u.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s no result: got %0d/%0d pending, want 0", name, q_o.size(), q_u.size());
            q_o.delete();
            q_u.delete();
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ord busy"},      {31'd0, o_busy}, 32'd0);
        checkOutput({tag, " ord done"},      {31'd0, o_done}, 32'd0);
        checkOutput({tag, " ord pass"},      {31'd0, o_pass}, 32'd0);
        checkOutput({tag, " ord fail_code"}, {29'd0, o_fail_code}, 32'd0);
        checkOutput({tag, " ord match_cnt"}, {29'd0, o_match_cnt}, 32'd0);
        checkOutput({tag, " ord cycle_cnt"}, o_cycle_cnt, 32'd0);
        checkOutput({tag, " ord err_addr"},  o_err_addr, 32'd0);
        checkOutput({tag, " unord busy"},    {31'd0, u_busy}, 32'd0);
        checkOutput({tag, " unord done"},    {31'd0, u_done}, 32'd0);
        checkOutput({tag, " unord cycle_cnt"}, u_cycle_cnt, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_addr = '0; cfg_data = '0; cfg_count = '0;
        bus.mem_write = 1'b0; bus.data_adr = '0; bus.write_data = '0;
        #3 reset = 1'b0;
        #1 checkAllZero("reset");
        tick(); tick();
        reset = 1'b1;
        tick();

        // Ignored-window writes at both window ends, then the single hit.
        cfgEntry(2'd0, 32'd100, 32'd25);
        expectResult(1, 1, "window then hit", 1'b1, 3'd0, 3'd1, 32'd2, 32'd0, 32'd0);
        startRun(3'd1);
        applyStimulus(32'd96, 32'd7);
        applyStimulus(32'd99, 32'd3);
        applyStimulus(32'd100, 32'd25);
        waitDrained(20, "window then hit");

        expectResult(1, 1, "data mismatch", 1'b0, 3'd2, 3'd0, 32'd0, 32'd100, 32'd24);
        startRun(3'd1);
        applyStimulus(32'd100, 32'd24);
        waitDrained(20, "data mismatch");

        expectResult(1, 1, "unexpected addr", 1'b0, 3'd1, 3'd0, 32'd0, 32'd104, 32'd25);
        startRun(3'd1);
        applyStimulus(32'd104, 32'd25);
        waitDrained(20, "unexpected addr");

        expectResult(1, 1, "below window", 1'b0, 3'd1, 3'd0, 32'd0, 32'd95, 32'd25);
        startRun(3'd1);
        applyStimulus(32'd95, 32'd25);
        waitDrained(20, "below window");

        // Out-of-order pair: ordered checker rejects, unordered accepts.
        cfgEntry(2'd1, 32'd104, 32'd7);
        expectResult(1, 0, "out of order", 1'b0, 3'd1, 3'd0, 32'd0, 32'd104, 32'd7);
        expectResult(0, 1, "out of order", 1'b1, 3'd0, 3'd2, 32'd1, 32'd0, 32'd0);
        startRun(3'd2);
        applyStimulus(32'd104, 32'd7);
        applyStimulus(32'd100, 32'd25);
        waitDrained(20, "out of order");

        // Repeating an already-hit address is unexpected in both modes.
        expectResult(1, 1, "repeat addr", 1'b0, 3'd1, 3'd1, 32'd1, 32'd100, 32'd25);
        startRun(3'd2);
        applyStimulus(32'd100, 32'd25);
        applyStimulus(32'd100, 32'd25);
        waitDrained(20, "repeat addr");

        expectResult(1, 1, "timeout", 1'b0, 3'd3, 3'd0, 32'd49, 32'd0, 32'd0);
        startRun(3'd1);
        waitDrained(70, "timeout");

        // Final hit on the timeout cycle: pass takes priority.
        expectResult(1, 1, "hit on last cycle", 1'b1, 3'd0, 3'd1, 32'd49, 32'd0, 32'd0);
        startRun(3'd1);
        repeat (49) tick();
        applyStimulus(32'd100, 32'd25);
        waitDrained(20, "hit on last cycle");

        // Asynchronous abort in the middle of a run.
        startRun(3'd1);
        repeat (3) tick();
        checkOutput("midrun ord busy", {31'd0, o_busy}, 32'd1);
        checkOutput("midrun ord cycle_cnt", o_cycle_cnt, 32'd3);
        reset = 1'b0;
        #1 checkAllZero("midrun reset");
        tick();
        reset = 1'b1;
        tick(); tick();
        checkOutput("after reset ord busy", {31'd0, o_busy}, 32'd0);

        expectResult(1, 1, "empty cfg", 1'b0, 3'd4, 3'd0, 32'd0, 32'd0, 32'd0);
        startRun(3'd0);
        checkOutput("empty cfg ord done next cycle", {31'd0, o_done}, 32'd1);
        waitDrained(20, "empty cfg");

        // Table write during RUN must not land, during or after the run.
        cfgEntry(2'd0, 32'd100, 32'd25);
        expectResult(1, 1, "cfg during run", 1'b1, 3'd0, 3'd1, 32'd1, 32'd0, 32'd0);
        startRun(3'd1);
        cfgEntry(2'd0, 32'd200, 32'd9);
        applyStimulus(32'd100, 32'd25);
        waitDrained(20, "cfg during run");

        expectResult(1, 1, "after restart", 1'b1, 3'd0, 3'd1, 32'd0, 32'd0, 32'd0);
        startRun(3'd1);
        applyStimulus(32'd100, 32'd25);
        waitDrained(20, "after restart");

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
